// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// (IF) and data access (DM). DM normally wins. IF is forced through after
// STARVE_MAX consecutive lost arbitrations. Each access holds the port for
// MEM_LAT cycles. The owner's done pulse is raised in the last cycle.
module mem_port_arbiter #(
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic if_req,
   input  logic dm_req,
   input  logic dm_we,
   output logic mem_sel,
   output logic mem_en,
   output logic mem_we,
   output logic if_done,
   output logic dm_done,
   output logic if_stall,
   output logic dm_stall,
   output logic busy
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t     state;
   logic       owner;
   logic [3:0] lat_cnt;
   logic [3:0] starve_cnt;
   logic       we_lat;

   logic       arb_point;
   logic       grant_any;
   logic       grant_dm;
   logic [3:0] starve_next;

   // Arbitration decision and starvation counter update for the coming edge
   always_comb begin
      arb_point   = 1'b0;
      grant_any   = 1'b0;
      grant_dm    = 1'b0;
      starve_next = starve_cnt;
      if ((state == IDLE) || (lat_cnt == 4'd0)) begin
         arb_point = 1'b1;
      end else begin
         arb_point = 1'b0;
      end
      grant_any = if_req | dm_req;
      if (if_req && dm_req) begin
         // IF only wins a contested edge once it has lost STARVE_MAX in a row
         grant_dm = (starve_cnt != STARVE_LIM);
      end else begin
         grant_dm = dm_req;
      end
      if (!arb_point) begin
         starve_next = starve_cnt;
      end else if (if_req && dm_req && grant_dm) begin
         if (starve_cnt < STARVE_LIM) begin
            starve_next = starve_cnt + 4'd1;
         end else begin
            starve_next = STARVE_LIM;
         end
      end else begin
         // IF won, or IF is not asking: the losing streak is over
         starve_next = 4'd0;
      end
   end

   // Port FSM with registered memory controls and done pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         lat_cnt    <= 4'd0;
         starve_cnt <= 4'd0;
         we_lat     <= 1'b0;
         mem_sel    <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         if_done    <= 1'b0;
         dm_done    <= 1'b0;
      end else begin
         starve_cnt <= starve_next;
         if (arb_point) begin
            if (grant_any) begin
               // New access starts here, back-to-back with any finishing one
               state   <= ACCESS;
               owner   <= grant_dm;
               lat_cnt <= LAT_INIT;
               we_lat  <= grant_dm & dm_we;
               mem_en  <= 1'b1;
               mem_sel <= grant_dm;
               mem_we  <= grant_dm & dm_we;
               if_done <= ~grant_dm & (LAT_INIT == 4'd0);
               dm_done <= grant_dm & (LAT_INIT == 4'd0);
            end else begin
               state   <= IDLE;
               owner   <= 1'b0;
               lat_cnt <= 4'd0;
               we_lat  <= 1'b0;
               mem_en  <= 1'b0;
               mem_sel <= 1'b0;
               mem_we  <= 1'b0;
               if_done <= 1'b0;
               dm_done <= 1'b0;
            end
         end else begin
            // Mid-access: hold the port, flag done for the final cycle
            state   <= ACCESS;
            lat_cnt <= lat_cnt - 4'd1;
            mem_en  <= 1'b1;
            mem_sel <= owner;
            mem_we  <= we_lat;
            if_done <= ~owner & (lat_cnt == 4'd1);
            dm_done <= owner & (lat_cnt == 4'd1);
         end
      end
   end

   assign if_stall = if_req & ~if_done;
   assign dm_stall = dm_req & ~dm_done;
   assign busy     = mem_en;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboarded bench for mem_port_arbiter: instance a uses MEM_LAT=2,
// instance b uses MEM_LAT=1 (both STARVE_MAX=3).
module tb_mem_port_arbiter;

   typedef struct {
      logic sel;
      logic we;
      int   cyc;
   } rec_t;

   logic clk = 1'b0;
   int   ecnt = 0;
   int   checks = 0;
   int   errors = 0;

   rec_t sb_a[$];
   rec_t sb_b[$];

   logic rst_n_a, if_req_a, dm_req_a, dm_we_a;
   logic mem_sel_a, mem_en_a, mem_we_a, if_done_a, dm_done_a, if_stall_a, dm_stall_a, busy_a;
   logic rst_n_b, if_req_b, dm_req_b, dm_we_b;
   logic mem_sel_b, mem_en_b, mem_we_b, if_done_b, dm_done_b, if_stall_b, dm_stall_b, busy_b;

   mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(3)) u_a (
      .clk(clk), .rst_n(rst_n_a), .if_req(if_req_a), .dm_req(dm_req_a), .dm_we(dm_we_a),
      .mem_sel(mem_sel_a), .mem_en(mem_en_a), .mem_we(mem_we_a), .if_done(if_done_a),
      .dm_done(dm_done_a), .if_stall(if_stall_a), .dm_stall(dm_stall_a), .busy(busy_a)
   );

   mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) u_b (
      .clk(clk), .rst_n(rst_n_b), .if_req(if_req_b), .dm_req(dm_req_b), .dm_we(dm_we_b),
      .mem_sel(mem_sel_b), .mem_en(mem_en_b), .mem_we(mem_we_b), .if_done(if_done_b),
      .dm_done(dm_done_b), .if_stall(if_stall_b), .dm_stall(dm_stall_b), .busy(busy_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h (edge %0d)", tag, got, exp, ecnt);
      end
   endtask

   function automatic rec_t mk(input logic sel, input logic we, input int cyc);
      rec_t r;
      r.sel = sel;
      r.we  = we;
      r.cyc = cyc;
      return r;
   endfunction

   // Scoreboard for instance a: every done pulse must match a pushed access
   always @(negedge clk) begin
      rec_t r;
      check("a_if_stall", 32'(if_stall_a), 32'(if_req_a & ~if_done_a));
      check("a_dm_stall", 32'(dm_stall_a), 32'(dm_req_a & ~dm_done_a));
      check("a_busy", 32'(busy_a), 32'(mem_en_a));
      if (if_done_a | dm_done_a) begin
         if (sb_a.size() == 0) begin
            check("a_unexpected_done", 32'({if_done_a, dm_done_a}), 32'd0);
         end else begin
            r = sb_a.pop_front();
            check("a_done_owner", 32'({if_done_a, dm_done_a}), r.sel ? 32'd1 : 32'd2);
            check("a_done_sel", 32'(mem_sel_a), 32'(r.sel));
            check("a_done_we", 32'(mem_we_a), 32'(r.we));
            check("a_done_en", 32'(mem_en_a), 32'd1);
            check("a_done_cycle", 32'(ecnt), 32'(r.cyc));
         end
      end
   end

   // Scoreboard for instance b
   always @(negedge clk) begin
      rec_t r;
      check("b_if_stall", 32'(if_stall_b), 32'(if_req_b & ~if_done_b));
      check("b_dm_stall", 32'(dm_stall_b), 32'(dm_req_b & ~dm_done_b));
      if (if_done_b | dm_done_b) begin
         if (sb_b.size() == 0) begin
            check("b_unexpected_done", 32'({if_done_b, dm_done_b}), 32'd0);
         end else begin
            r = sb_b.pop_front();
            check("b_done_owner", 32'({if_done_b, dm_done_b}), r.sel ? 32'd1 : 32'd2);
            check("b_done_sel", 32'(mem_sel_b), 32'(r.sel));
            check("b_done_we", 32'(mem_we_b), 32'(r.we));
            check("b_done_en", 32'(mem_en_b), 32'd1);
            check("b_done_cycle", 32'(ecnt), 32'(r.cyc));
         end
      end
   end

   initial begin
      int e;
      rst_n_a = 1'b0; if_req_a = 1'b0; dm_req_a = 1'b0; dm_we_a = 1'b0;
      rst_n_b = 1'b0; if_req_b = 1'b0; dm_req_b = 1'b0; dm_we_b = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_en", 32'(mem_en_a), 32'd0);
      check("rst_sel", 32'(mem_sel_a), 32'd0);
      check("rst_we", 32'(mem_we_a), 32'd0);
      check("rst_done", 32'({if_done_a, dm_done_a}), 32'd0);
      check("rst_starve", 32'(u_a.starve_cnt), 32'd0);
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;
      @(negedge clk);

      // Single IF read
      e = ecnt; if_req_a = 1'b1;
      sb_a.push_back(mk(1'b0, 1'b0, e + 2));
      #1 check("t1_stall_c0", 32'(if_stall_a), 32'd1);
      check("t1_en_c0", 32'(mem_en_a), 32'd0);
      @(negedge clk);
      check("t1_en_c1", 32'(mem_en_a), 32'd1);
      check("t1_sel_c1", 32'(mem_sel_a), 32'd0);
      check("t1_ifdone_c1", 32'(if_done_a), 32'd0);
      check("t1_stall_c1", 32'(if_stall_a), 32'd1);
      @(negedge clk);
      check("t1_ifdone_c2", 32'(if_done_a), 32'd1);
      check("t1_stall_c2", 32'(if_stall_a), 32'd0);
      if_req_a = 1'b0;
      @(negedge clk);
      check("t1_idle_c3", 32'(mem_en_a), 32'd0);

      // Contention: DM write first, IF follows without a bubble
      e = ecnt; if_req_a = 1'b1; dm_req_a = 1'b1; dm_we_a = 1'b1;
      sb_a.push_back(mk(1'b1, 1'b1, e + 2));
      sb_a.push_back(mk(1'b0, 1'b0, e + 4));
      @(negedge clk);
      check("t2_sel_c1", 32'(mem_sel_a), 32'd1);
      check("t2_we_c1", 32'(mem_we_a), 32'd1);
      @(negedge clk);
      dm_req_a = 1'b0; dm_we_a = 1'b0;
      @(negedge clk);
      check("t2_en_c3", 32'(mem_en_a), 32'd1);
      check("t2_sel_c3", 32'(mem_sel_a), 32'd0);
      check("t2_we_c3", 32'(mem_we_a), 32'd0);
      @(negedge clk);
      if_req_a = 1'b0;
      @(negedge clk);
      check("t2_idle_c5", 32'(mem_en_a), 32'd0);

      // Starvation guard: DM three times, then IF, then DM again
      e = ecnt; if_req_a = 1'b1; dm_req_a = 1'b1; dm_we_a = 1'b0;
      sb_a.push_back(mk(1'b1, 1'b0, e + 2));
      sb_a.push_back(mk(1'b1, 1'b0, e + 4));
      sb_a.push_back(mk(1'b1, 1'b0, e + 6));
      sb_a.push_back(mk(1'b0, 1'b0, e + 8));
      sb_a.push_back(mk(1'b1, 1'b0, e + 10));
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check("t3_en", 32'(mem_en_a), 32'd1);
         if (c == 5) check("t3_starve_sat", 32'(u_a.starve_cnt), 32'd3);
         if (c == 8) if_req_a = 1'b0;
         if (c == 10) dm_req_a = 1'b0;
      end
      @(negedge clk);
      check("t3_starve_clr", 32'(u_a.starve_cnt), 32'd0);
      check("t3_idle", 32'(mem_en_a), 32'd0);

      // DM request pulsed for a single cycle
      e = ecnt; dm_req_a = 1'b1;
      sb_a.push_back(mk(1'b1, 1'b0, e + 2));
      @(negedge clk);
      dm_req_a = 1'b0;
      check("t4_en_c1", 32'(mem_en_a), 32'd1);
      @(negedge clk);
      check("t4_en_c2", 32'(mem_en_a), 32'd1);
      @(negedge clk);
      check("t4_idle_c3", 32'(mem_en_a), 32'd0);
      @(negedge clk);
      check("t4_idle_c4", 32'(mem_en_a), 32'd0);

      // Reset in the first cycle of a DM write aborts it without a done
      dm_req_a = 1'b1; dm_we_a = 1'b1;
      @(negedge clk);
      check("t5_en_pre", 32'(mem_en_a), 32'd1);
      check("t5_we_pre", 32'(mem_we_a), 32'd1);
      rst_n_a = 1'b0;
      #1;
      check("t5_en_async", 32'(mem_en_a), 32'd0);
      check("t5_we_async", 32'(mem_we_a), 32'd0);
      check("t5_sel_async", 32'(mem_sel_a), 32'd0);
      @(negedge clk);
      check("t5_done_rst", 32'(dm_done_a), 32'd0);
      e = ecnt; rst_n_a = 1'b1;
      sb_a.push_back(mk(1'b1, 1'b1, e + 2));
      @(negedge clk);
      check("t5_regrant", 32'(mem_en_a), 32'd1);
      check("t5_regrant_sel", 32'(mem_sel_a), 32'd1);
      @(negedge clk);
      dm_req_a = 1'b0; dm_we_a = 1'b0;
      @(negedge clk);
      check("t5_idle", 32'(mem_en_a), 32'd0);

      // MEM_LAT=1: alternating single-cycle accesses
      e = ecnt; if_req_b = 1'b1; dm_req_b = 1'b1; dm_we_b = 1'b1;
      sb_b.push_back(mk(1'b1, 1'b1, e + 1));
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         check("t6_en", 32'(mem_en_b), 32'd1);
         check("t6_sel", 32'(mem_sel_b), 32'(c % 2));
         if (c == 6) begin
            if_req_b = 1'b0; dm_req_b = 1'b0;
         end else if (c % 2 == 1) begin
            dm_req_b = 1'b0; if_req_b = 1'b1;
            sb_b.push_back(mk(1'b0, 1'b0, e + c + 1));
         end else begin
            dm_req_b = 1'b1; if_req_b = 1'b0;
            sb_b.push_back(mk(1'b1, 1'b1, e + c + 1));
         end
      end
      @(negedge clk);
      check("t6_idle", 32'(mem_en_b), 32'd0);

      repeat (2) @(negedge clk);
      check("sb_a_empty", 32'(sb_a.size()), 32'd0);
      check("sb_b_empty", 32'(sb_b.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
